seq_sub16_slice: RTL and testbench

- Multi-cycle 16-bit subtractor, the inverse operation of the team's 16-bit CLA adder chain.
- Evaluates A − B as A + ~B + 1, one SLICE_W-bit slice per clock, LSB slice first. The borrow/carry is held in a register between slices.
- Start/busy/done handshake; sits beside the adders in the datapath, where area matters more than single-cycle latency.

---
 rtl/seq_sub16_slice.sv | 181 ++++++++++++++++++
 tb/tb_seq_sub16_slice.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_sub16_slice.sv
// seq_sub16_slice: multi-cycle subtractor computing A - B as A + ~B + 1,
// one SLICE_W-bit slice per clock, LSB slice first, with the carry held in a
// register between slices. Start/busy/done handshake.
//
// Optional build macro: SEQ_SUB_ADD_MODE_EN
//   When defined, an extra 'op' input selects add (op=1) or subtract (op=0);
//   op is latched with the operands on the accepted start.
//
// Handshake: start is sampled only in IDLE; an accepted start raises busy on
// the same edge. busy stays high for NSLICE cycles, then done pulses for one
// cycle while the results land on D/Bout/Ovf/Zero. start is ignored while
// busy or done is high. D and flags hold until the next operation completes.
//
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for checkers.

module seq_sub16_slice #(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero,
    output logic [1:0]       dbg_state
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] res_q, res_n;
    logic             carry_q, carry_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             busy_n, done_n, bout_n, ovf_n, zero_n;
    logic [WIDTH-1:0] d_n;

    // Slice datapath signals
    int               slice_base;
    logic [SLICE_W-1:0] a_s, b_s, b_e;
    logic [SLICE_W:0]   sum;
    logic [WIDTH-1:0]   res_full;
    logic               last_slice;

    // sub_mode: 1 = subtract (invert B, carry-in 1), 0 = add.
    // start_carry: carry register value loaded on an accepted start.
    logic sub_mode;
    logic start_carry;

`ifdef SEQ_SUB_ADD_MODE_EN
    logic op_q;

    // Latch the operation select together with the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            op_q <= op;
        end
    end

    assign sub_mode    = ~op_q;
    assign start_carry = ~op;
`else
    assign sub_mode    = 1'b1;
    assign start_carry = 1'b1;
`endif

    assign dbg_state = state;

    // Next-state and datapath: one slice of A + B' + carry per RUN cycle
    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        res_n    = res_q;
        carry_n  = carry_q;
        cnt_n    = cnt_q;
        busy_n   = busy;
        done_n   = 1'b0;
        d_n      = D;
        bout_n   = Bout;
        ovf_n    = Ovf;
        zero_n   = Zero;

        slice_base = int'(cnt_q) * SLICE_W;
        a_s        = a_q[slice_base +: SLICE_W];
        b_s        = b_q[slice_base +: SLICE_W];
        b_e        = sub_mode ? ~b_s : b_s;
        sum        = {1'b0, a_s} + {1'b0, b_e} + {{SLICE_W{1'b0}}, carry_q};
        res_full   = res_q;
        res_full[slice_base +: SLICE_W] = sum[SLICE_W-1:0];
        last_slice = (cnt_q == CW'(NSLICE - 1));

        case (state)
            S_IDLE: begin
                if (start) begin
                    a_n     = A;
                    b_n     = B;
                    carry_n = start_carry;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                res_n   = res_full;
                carry_n = sum[SLICE_W];
                cnt_n   = cnt_q + CW'(1);
                if (last_slice) begin
                    // Final slice: publish result and flags from latched operands
                    d_n     = res_full;
                    bout_n  = sub_mode ? ~sum[SLICE_W] : sum[SLICE_W];
                    ovf_n   = (a_q[MSB] == (sub_mode ? ~b_q[MSB] : b_q[MSB])) &&
                              (res_full[MSB] != a_q[MSB]);
                    zero_n  = (res_full == '0);
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and register update; synchronous reset discards any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
            Ovf     <= 1'b0;
            Zero    <= 1'b0;
        end else begin
            state   <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            res_q   <= res_n;
            carry_q <= carry_n;
            cnt_q   <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            D       <= d_n;
            Bout    <= bout_n;
            Ovf     <= ovf_n;
            Zero    <= zero_n;
        end
    end

endmodule

// File: tb/tb_seq_sub16_slice.sv
// tb_seq_sub16_slice: randomized and directed bench for seq_sub16_slice.
// Expected results come from plain integer arithmetic on the operands;
// they are queued at issue time and popped when done pulses.

module tb_seq_sub16_slice;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] D;
    logic        Bout;
    logic        Ovf;
    logic        Zero;
    logic [1:0]  dbg_state;
`ifdef SEQ_SUB_ADD_MODE_EN
    logic        op;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    logic [18:0] exp_q[$];
    logic [15:0] last_d;

    // Clock
    always #5 clk = ~clk;

    seq_sub16_slice dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SEQ_SUB_ADD_MODE_EN
        .op        (op),
`endif
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .D         (D),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero),
        .dbg_state (dbg_state)
    );

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {D[15:0], Bout, Ovf, Zero} from integer arithmetic
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic add);
        int          sa, sb, sr;
        logic [16:0] u;
        logic [15:0] d;
        logic        bo, ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (add) begin
            u  = {1'b0, a} + {1'b0, b};
            bo = u[16];
            sr = sa + sb;
        end else begin
            u  = {1'b0, a} - {1'b0, b};
            bo = (a < b);
            sr = sa - sb;
        end
        d  = u[15:0];
        ov = (sr > 32767) || (sr < -32768);
        return {d, bo, ov, (d == 16'h0)};
    endfunction

    // Issue one operation and check it; glitch=1 re-pulses start during RUN
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic o,
                         input bit glitch);
        int          lat;
        logic [18:0] e;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
`ifdef SEQ_SUB_ADD_MODE_EN
        op    = o;
`endif
        exp_q.push_back(model(a, b, o));
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        check("busy_rise", busy, 1);
        check("done_early", done, 0);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (glitch && lat == 1) begin
                start = 1'b1;
                A     = 16'hFFFF;
                B     = ~b;
`ifdef SEQ_SUB_ADD_MODE_EN
                op    = ~o;
`endif
            end else begin
                start = 1'b0;
                A     = 16'($urandom);
                B     = 16'($urandom);
            end
            if (!done && lat == 2) check("d_hold", D, last_d);
        end
        start = 1'b0;
        check("latency", lat, NS);
        check("busy_fall", busy, 0);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("d", D, e[18:3]);
        check("bout", Bout, e[2]);
        check("ovf", Ovf, e[1]);
        check("zero", Zero, e[0]);
        last_d = e[18:3];
        // start during DONE must be ignored
        start = 1'b1;
        A     = 16'($urandom);
        B     = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_len", done, 0);
        check("start_in_done", busy, 0);
    endtask

    // Reset during the 2nd RUN cycle discards the operation
    task automatic abort_test(input logic [15:0] a, input logic [15:0] b);
        int n_done;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_d", D, 0);
        check("abort_flags", {Bout, Ovf, Zero}, 0);
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        last_d = 16'h0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Main sequence
    initial begin
        logic [15:0] ra, rb;
        logic        ro;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef SEQ_SUB_ADD_MODE_EN
        op    = 1'b0;
`endif
        last_d = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", D, 0);
        check("rst_flags", {Bout, Ovf, Zero}, 0);
        rst = 1'b0;

        do_op(16'h1234, 16'h0234, 1'b0, 0);
        check("tp_d_1000", D, 16'h1000);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        check("tp_d_ffff", D, 16'hFFFF);
        check("tp_bout_1", Bout, 1);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        check("tp_ovf_1", Ovf, 1);
        do_op(16'hABCD, 16'hABCD, 1'b0, 0);
        check("tp_zero_1", Zero, 1);
        do_op(16'h00FF, 16'h0001, 1'b0, 1);
        check("tp_glitch_d", D, 16'h00FE);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);

        abort_test(16'h5555, 16'h1111);
        do_op(16'h4000, 16'hC000, 1'b0, 0);

        // rst and start together: rst wins
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);
        last_d = 16'h0;

`ifdef SEQ_SUB_ADD_MODE_EN
        do_op(16'hFFFF, 16'h0001, 1'b1, 0);
        check("add_zero", Zero, 1);
        check("add_carry", Bout, 1);
        do_op(16'h7FFF, 16'h0001, 1'b1, 0);
        check("add_d_8000", D, 16'h8000);
        check("add_ovf", Ovf, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 16'($urandom); rb = ra; end
                1: begin ra = 16'h8000; rb = 16'($urandom_range(0, 3)); end
                2: begin ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); end
                default: begin ra = 16'($urandom); rb = 16'($urandom); end
            endcase
`ifdef SEQ_SUB_ADD_MODE_EN
            ro = 1'($urandom_range(0, 1));
`else
            ro = 1'b0;
`endif
            do_op(ra, rb, ro, (i % 7) == 3);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
